// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - multi-channel parallel ADC capture controller with FWFT sample FIFO
// Sweeps NUM_CH mux channels per divider tick, strobes the ADC and queues {channel,sample} words.
module adc_capture_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CONV_PULSE = 2,
  parameter int CONV_CYC   = 60,
  parameter int RD_CYC     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              convstb,
  output logic              csb,
  output logic              rdb,
  output logic [CH_W-1:0]   ch_sel,
  input  logic [DATA_W-1:0] db,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              busy
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WORD_W = CH_W + DATA_W;
  localparam int TMR_W  = 16;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_WAIT,
    S_READ,
    S_STORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  w_div_last;
  logic              w_tick;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_last;
  logic              w_tmr_done;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_sample;
  logic              r_convstb;
  logic              r_csb;
  logic              r_rdb;
  logic              r_overflow;

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_push_ok;
  logic [WORD_W-1:0] w_head;

  // A count already past a newly lowered rate_div wraps on the next cycle.
  assign w_div_last = (rate_div == '0) ? '0 : rate_div - DIV_W'(1);
  assign w_tick     = en && (r_div_cnt >= w_div_last);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    w_tmr_last = '0;
    case (r_state)
      S_SETTLE: w_tmr_last = TMR_W'(SETTLE_CYC - 1);
      S_CONV:   w_tmr_last = TMR_W'(CONV_PULSE - 1);
      S_WAIT:   w_tmr_last = TMR_W'(CONV_CYC - 1);
      S_READ:   w_tmr_last = TMR_W'(RD_CYC - 1);
      default:  w_tmr_last = '0;
    endcase
  end

  assign w_tmr_done = (r_tmr == w_tmr_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_next = S_SETTLE;
      S_SETTLE: if (w_tmr_done) w_next = S_CONV;
      S_CONV:   if (w_tmr_done) w_next = S_WAIT;
      S_WAIT:   if (w_tmr_done) w_next = S_READ;
      S_READ:   if (w_tmr_done) w_next = S_STORE;
      S_STORE:  w_next = (r_ch == LAST_CH) ? S_IDLE : S_SETTLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_next;
      r_tmr   <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch <= '0;
    end else if (r_state == S_STORE) begin
      r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '0;
    end else if (r_state == S_READ && w_tmr_done) begin
      r_sample <= db;
    end
  end

  // Strobes are registered from the next state so they toggle on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_convstb <= 1'b1;
      r_csb     <= 1'b1;
      r_rdb     <= 1'b1;
    end else begin
      r_convstb <= (w_next != S_CONV);
      r_csb     <= (w_next != S_READ);
      r_rdb     <= (w_next != S_READ);
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = (r_state == S_STORE);
  assign w_pop     = !w_empty && m_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_ch, r_sample};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_push && !w_push_ok) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign m_valid  = !w_empty;
  assign m_data   = w_head[DATA_W-1:0];
  assign m_ch     = w_head[WORD_W-1:DATA_W];
  assign overflow = r_overflow;
  assign convstb  = r_convstb;
  assign csb      = r_csb;
  assign rdb      = r_rdb;
  assign ch_sel   = r_ch;
  assign busy     = (r_state != S_IDLE);

endmodule
